ehl_gpio_in: RTL and testbench

Input-side GPIO block: captures asynchronous pad inputs, synchronizes them, optionally debounces each bit, detects rising and falling edges, and accumulates them in a sticky, write-1-to-clear interrupt status register with a single aggregated interrupt output. It sits between the pad ring and the GPIO bus-register file, alongside the output data register, and supplies the readable input-value and interrupt-status words.

---
 rtl/ehl_gpio_pkg.sv | 15 +
 rtl/ehl_gpio_in_if.sv | 28 ++
 rtl/ehl_gpio_in_filter.sv | 67 ++++++
 rtl/ehl_gpio_in.sv | 64 ++++++
 tb/tb_ehl_gpio_in.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ehl_gpio_pkg.sv
// Shared GPIO constants and types used by the input and output register blocks.
// Also defines the per-bit edge event that the filter reports to the status logic.
package ehl_gpio_pkg;

    localparam int GPIO_WIDTH       = 32;
    localparam int GPIO_SYNC_STAGES = 2;
    localparam int GPIO_DEBOUNCE_W  = 4;

    // Per-bit edge report: changed pulses while f is about to update; rising gives the new level.
    typedef struct packed {
        logic changed;
        logic rising;
    } edge_evt_t;

endpackage

// File: rtl/ehl_gpio_in_if.sv
// Bundle between the pad/register-file side (master) and the ehl_gpio_in block (slave).
interface ehl_gpio_in_if
    import ehl_gpio_pkg::*;
#(
    parameter int WIDTH      = GPIO_WIDTH,
    parameter int DEBOUNCE_W = GPIO_DEBOUNCE_W
);
    logic [WIDTH-1:0]      gpio_in;
    logic [WIDTH-1:0]      debounce_en;
    logic [DEBOUNCE_W-1:0] filt_len;
    logic [WIDTH-1:0]      rise_en;
    logic [WIDTH-1:0]      fall_en;
    logic                  clr_wr;
    logic [WIDTH-1:0]      clr_data;
    logic [WIDTH-1:0]      gpio_value;
    logic [WIDTH-1:0]      irq_status;
    logic                  irq;

    modport master (
        output gpio_in, debounce_en, filt_len, rise_en, fall_en, clr_wr, clr_data,
        input  gpio_value, irq_status, irq
    );

    modport slave (
        input  gpio_in, debounce_en, filt_len, rise_en, fall_en, clr_wr, clr_data,
        output gpio_value, irq_status, irq
    );
endinterface

// File: rtl/ehl_gpio_in_filter.sv
// One GPIO bit: pad synchronizer, optional debounce counter and filtered value f.
// Reports a combinational edge event in the cycle before f takes its new value.
module ehl_gpio_in_filter
    import ehl_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pad,
    input  logic                  debounce_en,
    input  logic [DEBOUNCE_W-1:0] filt_len,
    output logic                  f,
    output edge_evt_t             evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DEBOUNCE_W-1:0]  cnt_q;
    logic [DEBOUNCE_W-1:0]  cnt_next;
    logic                   f_next;

    // NOTE: the synchronizer flops are reset too, so no stale pad level survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    // Only the last stage is observed; earlier stages may be metastable.
    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: defaults first, so every path assigns f_next/cnt_next and no latch is inferred.
    always_comb begin
        f_next   = f;
        cnt_next = cnt_q;
        if (!debounce_en) begin
            f_next   = s;
            cnt_next = '0;
        end else if (s == f) begin
            cnt_next = '0;
        end else if (cnt_q >= filt_len) begin
            f_next   = s;
            cnt_next = '0;
        end else if (cnt_q != {DEBOUNCE_W{1'b1}}) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f     <= 1'b0;
            cnt_q <= '0;
        end else begin
            f     <= f_next;
            cnt_q <= cnt_next;
        end
    end

    assign evt.changed = f_next ^ f;
    assign evt.rising  = f_next;

endmodule

// File: rtl/ehl_gpio_in.sv
// GPIO input block: per-bit filters plus sticky write-1-to-clear edge status
// and an aggregated, registered interrupt.
module ehl_gpio_in
    import ehl_gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
    input  logic          clk,
    input  logic          reset_n,
    ehl_gpio_in_if.slave  bus
);

    logic [WIDTH-1:0] value;
    edge_evt_t        evt [WIDTH];
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_next;
    logic             irq_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ehl_gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_filter (
            .clk         (clk),
            .reset_n     (reset_n),
            .pad         (bus.gpio_in[gi]),
            .debounce_en (bus.debounce_en[gi]),
            .filt_len    (bus.filt_len),
            .f           (value[gi]),
            .evt         (evt[gi])
        );
    end

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_mask[i] = evt[i].changed &
                          ((evt[i].rising & bus.rise_en[i]) | (~evt[i].rising & bus.fall_en[i]));
        end
    end

    // A new event in the same cycle as its clear survives: set is OR-ed in after the clear.
    assign clr_mask    = bus.clr_wr ? bus.clr_data : '0;
    assign status_next = (status_q & ~clr_mask) | set_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_next;
            irq_q    <= |status_q;  // irq trails irq_status by one cycle
        end
    end

    assign bus.gpio_value = value;
    assign bus.irq_status = status_q;
    assign bus.irq        = irq_q;

endmodule

// File: tb/tb_ehl_gpio_in.sv
// Bench for ehl_gpio_in: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_ehl_gpio_in;
    import ehl_gpio_pkg::*;

    localparam int W = GPIO_WIDTH;

    typedef enum int {SIG_VALUE, SIG_STATUS, SIG_IRQ} sig_e;
    typedef struct {
        int           cyc;
        sig_e         sig;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic clk   = 1'b0;
    logic reset_n = 1'b0;

    ehl_gpio_in_if bus ();

    ehl_gpio_in dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect sig == val when sampled k cycles (k >= 1) after the current negedge.
    task automatic exp_at(input int k, input sig_e sig, input logic [W-1:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + k;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            logic [W-1:0] act;
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sig)
                    SIG_VALUE:  act = bus.gpio_value;
                    SIG_STATUS: act = bus.irq_status;
                    default:    act = {{(W-1){1'b0}}, bus.irq};
                endcase
                n_cmp++;
                if (sb[i].cyc != cyc || act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d, due %0d): got 0x%08h, expected 0x%08h",
                             sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.gpio_in     = 32'h0000_0001;
        bus.debounce_en = '0;
        bus.filt_len    = '0;
        bus.rise_en     = 32'h0000_0001;
        bus.fall_en     = '0;
        bus.clr_wr      = 1'b0;
        bus.clr_data    = '0;

        // Reset state
        tick(1);
        exp_at(2, SIG_VALUE,  32'h0, "rst_value");
        exp_at(2, SIG_STATUS, 32'h0, "rst_status");
        exp_at(2, SIG_IRQ,    32'h0, "rst_irq");
        tick(3);

        // Pad high through reset: rising edge reported after release
        reset_n = 1'b1;
        exp_at(2, SIG_VALUE,  32'h0, "rel_value_e2");
        exp_at(3, SIG_VALUE,  32'h1, "rel_value_e3");
        exp_at(2, SIG_STATUS, 32'h0, "rel_status_e2");
        exp_at(3, SIG_STATUS, 32'h1, "rel_status_e3");
        exp_at(3, SIG_IRQ,    32'h0, "rel_irq_e3");
        exp_at(4, SIG_IRQ,    32'h1, "rel_irq_e4");
        tick(5);

        bus.rise_en  = '0;
        bus.clr_wr   = 1'b1;
        bus.clr_data = 32'h0000_0001;
        exp_at(1, SIG_STATUS, 32'h0, "clr0_status");
        exp_at(1, SIG_IRQ,    32'h1, "clr0_irq_lag");
        exp_at(2, SIG_IRQ,    32'h0, "clr0_irq_off");
        tick(1);
        bus.clr_wr   = 1'b0;
        bus.clr_data = '0;
        bus.gpio_in  = '0;
        tick(6);

        // Bypass toggle on bit 5
        bus.rise_en = 32'h0000_0020;
        bus.fall_en = 32'h0000_0020;
        bus.gpio_in = 32'h0000_0020;
        exp_at(2, SIG_VALUE,  32'h0,  "b5_value_e2");
        exp_at(3, SIG_VALUE,  32'h20, "b5_value_e3");
        exp_at(2, SIG_STATUS, 32'h0,  "b5_status_e2");
        exp_at(3, SIG_STATUS, 32'h20, "b5_rise_e3");
        exp_at(4, SIG_IRQ,    32'h1,  "b5_irq_e4");
        tick(10);
        bus.clr_wr   = 1'b1;
        bus.clr_data = 32'h0000_0020;
        exp_at(1, SIG_STATUS, 32'h0, "b5_clr");
        tick(1);
        bus.clr_wr   = 1'b0;
        bus.clr_data = '0;
        tick(9);
        bus.gpio_in = '0;
        exp_at(2, SIG_STATUS, 32'h0,  "b5_fall_e2");
        exp_at(3, SIG_STATUS, 32'h20, "b5_fall_e3");
        exp_at(3, SIG_VALUE,  32'h0,  "b5_fall_value");
        tick(10);

        // Clear-all in the same cycle as a rising edge on bit 7
        bus.rise_en = 32'h0000_00A0;
        bus.gpio_in = 32'h0000_0080;
        tick(2);
        bus.clr_wr   = 1'b1;
        bus.clr_data = '1;
        exp_at(1, SIG_STATUS, 32'h80, "b7_set_wins");
        exp_at(1, SIG_VALUE,  32'h80, "b7_value");
        exp_at(1, SIG_IRQ,    32'h1,  "b7_irq_hold1");
        exp_at(2, SIG_IRQ,    32'h1,  "b7_irq_hold2");
        tick(1);
        bus.clr_wr   = 1'b0;
        bus.clr_data = '0;
        tick(3);
        bus.clr_wr   = 1'b1;
        bus.clr_data = 32'h0000_0080;
        exp_at(1, SIG_STATUS, 32'h0, "b7_clr");
        exp_at(2, SIG_IRQ,    32'h0, "b7_irq_off");
        tick(1);
        bus.clr_wr   = 1'b0;
        bus.clr_data = '0;
        tick(3);

        // Debounce on bit 2, filt_len=3: 3-cycle glitch is filtered out
        bus.filt_len    = 4'd3;
        bus.debounce_en = 32'h0000_0004;
        bus.rise_en     = 32'h0000_0004;
        bus.fall_en     = 32'h0000_0004;
        bus.gpio_in     = 32'h0000_0084;
        exp_at(3, SIG_VALUE,  32'h80, "db_glitch_v3");
        exp_at(6, SIG_VALUE,  32'h80, "db_glitch_v6");
        exp_at(8, SIG_VALUE,  32'h80, "db_glitch_v8");
        exp_at(6, SIG_STATUS, 32'h0,  "db_glitch_s6");
        exp_at(9, SIG_STATUS, 32'h0,  "db_glitch_s9");
        tick(3);
        bus.gpio_in = 32'h0000_0080;
        tick(8);

        // Stable high is accepted at E6
        bus.gpio_in = 32'h0000_0084;
        exp_at(5, SIG_VALUE,  32'h80, "db_stable_v5");
        exp_at(6, SIG_VALUE,  32'h84, "db_stable_v6");
        exp_at(5, SIG_STATUS, 32'h0,  "db_stable_s5");
        exp_at(6, SIG_STATUS, 32'h4,  "db_stable_s6");
        exp_at(6, SIG_IRQ,    32'h0,  "db_stable_i6");
        exp_at(7, SIG_IRQ,    32'h1,  "db_stable_i7");
        tick(10);

        // Enables off: value tracks pads, no status
        bus.rise_en     = '0;
        bus.fall_en     = '0;
        bus.debounce_en = '0;
        bus.clr_wr      = 1'b1;
        bus.clr_data    = '1;
        tick(1);
        bus.clr_wr   = 1'b0;
        bus.clr_data = '0;
        tick(2);
        bus.gpio_in = 32'hA5A5_0F0F;
        exp_at(3, SIG_VALUE,  32'hA5A5_0F0F, "off_value_a");
        exp_at(3, SIG_STATUS, 32'h0, "off_status_a3");
        exp_at(4, SIG_STATUS, 32'h0, "off_status_a4");
        exp_at(5, SIG_IRQ,    32'h0, "off_irq_a");
        tick(5);
        bus.gpio_in = 32'h5A5A_F0F0;
        exp_at(3, SIG_VALUE,  32'h5A5A_F0F0, "off_value_b");
        exp_at(4, SIG_STATUS, 32'h0, "off_status_b");
        exp_at(5, SIG_IRQ,    32'h0, "off_irq_b");
        tick(5);

        // Reset mid-count, filt_len=15
        bus.gpio_in = '0;
        tick(5);
        bus.debounce_en = '1;
        bus.filt_len    = 4'd15;
        bus.rise_en     = '1;
        bus.fall_en     = '1;
        tick(1);
        bus.gpio_in = 32'h0000_0001;
        tick(10);
        reset_n     = 1'b0;
        bus.gpio_in = '0;
        exp_at(1, SIG_VALUE,  32'h0, "mid_rst_value");
        exp_at(1, SIG_STATUS, 32'h0, "mid_rst_status");
        exp_at(1, SIG_IRQ,    32'h0, "mid_rst_irq");
        tick(2);
        reset_n = 1'b1;
        exp_at(3,  SIG_STATUS, 32'h0, "mid_rel_s3");
        exp_at(10, SIG_STATUS, 32'h0, "mid_rel_s10");
        exp_at(10, SIG_VALUE,  32'h0, "mid_rel_v10");
        exp_at(11, SIG_IRQ,    32'h0, "mid_rel_i11");
        tick(12);

        // Counter restarted from 0: full 16-cycle filter before the update
        bus.gpio_in = 32'h0000_0001;
        exp_at(17, SIG_VALUE,  32'h0, "mid_cnt_v17");
        exp_at(18, SIG_VALUE,  32'h1, "mid_cnt_v18");
        exp_at(17, SIG_STATUS, 32'h0, "mid_cnt_s17");
        exp_at(18, SIG_STATUS, 32'h1, "mid_cnt_s18");
        exp_at(19, SIG_IRQ,    32'h1, "mid_cnt_i19");
        tick(22);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
